// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges decode/execute stall requests and sequences
// multi-cycle execute ops. Optional stall statistics counter under PIPE_CTRL_STALL_STAT_EN.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int STAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             mc_start_i,
  input  logic [CNT_W-1:0] mc_cycles_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             mc_busy_o,
  output logic             mc_done_o
`ifdef PIPE_CTRL_STALL_STAT_EN
  ,
  output logic [STAT_W-1:0] stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stall vector bit order: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] start_cnt;

  // A requested length of 0 behaves like 1.
  assign start_cnt = (mc_cycles_i == '0) ? '0 : mc_cycles_i - CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_start_i) begin
            state <= RUN;
            cnt   <= start_cnt;
          end
        end
        RUN: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: outputs get a default before the priority chain so no path infers a latch.
  always_comb begin
    stall_o = STALL_NONE;
    flush_o = 1'b0;
    if (rst) begin
      stall_o = STALL_NONE;
    end else if (flush_i) begin
      flush_o = 1'b1;
    end else if (stallreq_ex_i || state == RUN || (state == IDLE && mc_start_i)) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

  assign mc_busy_o = !rst && (state == RUN);
  assign mc_done_o = !rst && (state == DONE);

`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [STAT_W-1:0] stall_cycles_q;

  // Saturating count of cycles with any stage stalled; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_o != STALL_NONE && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + STAT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`else
  // STAT_W only sizes the statistics counter, which this build omits.
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; covers reset, load-use, multi-cycle
// sequencing, flush abort and, with PIPE_CTRL_STALL_STAT_EN, the stall statistics counter.
module tb_pipe_ctrl;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id_i;
  logic             stallreq_ex_i;
  logic             mc_start_i;
  logic [CNT_W-1:0] mc_cycles_i;
  logic             flush_i;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic             mc_busy_o;
  logic             mc_done_o;
`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [31:0]      stall_cycles_o;
  logic [5:0]       sat_stall;
  logic             sat_flush, sat_busy, sat_done;
  logic [1:0]       sat_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .STAT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .mc_start_i    (mc_start_i),
    .mc_cycles_i   (mc_cycles_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mc_busy_o     (mc_busy_o),
    .mc_done_o     (mc_done_o)
`ifdef PIPE_CTRL_STALL_STAT_EN
    ,
    .stall_cycles_o(stall_cycles_o)
`endif
  );

`ifdef PIPE_CTRL_STALL_STAT_EN
  // Narrow counter instance so saturation is reachable in a few cycles.
  pipe_ctrl #(.CNT_W(CNT_W), .STAT_W(2)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .mc_start_i    (mc_start_i),
    .mc_cycles_i   (mc_cycles_i),
    .flush_i       (flush_i),
    .stall_o       (sat_stall),
    .flush_o       (sat_flush),
    .mc_busy_o     (sat_busy),
    .mc_done_o     (sat_done),
    .stall_cycles_o(sat_cycles)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge, outputs sampled 2 later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b0;
    mc_start_i    = 1'b0;
    flush_i       = 1'b0;
  endtask

  // Start an op of length n, count cycles with the execute-stall vector, expect a done pulse.
  task automatic run_op(input int n, input int exp_stalls, input string tag);
    int stalls = 0;
    mc_cycles_i = CNT_W'(n);
    mc_start_i  = 1'b1;
    #2;
    for (int i = 0; i < 200; i++) begin
      if (stall_o !== 6'b001111) break;
      stalls++;
      next();
      mc_start_i = 1'b0;
      #2;
    end
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_done"}, 32'(mc_done_o), 32'd1);
    check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    next();
    #2;
    check({tag, "_idle_done"}, 32'(mc_done_o), 32'd0);
    check({tag, "_idle_busy"}, 32'(mc_busy_o), 32'd0);
    next();
  endtask

  initial begin
    logic saw_done;

    // Reset held 3 cycles with start and id stall asserted.
    clear_inputs();
    mc_cycles_i   = 6'd3;
    rst           = 1'b1;
    mc_start_i    = 1'b1;
    stallreq_id_i = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_flush", 32'(flush_o), 32'd0);
      check("rst_busy", 32'(mc_busy_o), 32'd0);
      check("rst_done", 32'(mc_done_o), 32'd0);
      next();
      #2;
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    check("post_rst_stall", 32'(stall_o), 32'd0);
    next();
    #2;
    check("post_rst_idle_busy", 32'(mc_busy_o), 32'd0);
    next();

    // Load-use stall for one cycle, then combined with an execute stall.
    stallreq_id_i = 1'b1;
    #2;
    check("load_use", 32'(stall_o), 32'b000111);
    next();
    stallreq_id_i = 1'b0;
    #2;
    check("load_use_off", 32'(stall_o), 32'd0);
    next();
    stallreq_id_i = 1'b1;
    stallreq_ex_i = 1'b1;
    #2;
    check("id_and_ex", 32'(stall_o), 32'b001111);
    next();
    clear_inputs();

    // N=3 step by step: stall t..t+3, busy t+1..t+3, done t+4, idle t+5.
    mc_cycles_i = 6'd3;
    mc_start_i  = 1'b1;
    #2;
    check("n3_t_stall", 32'(stall_o), 32'b001111);
    check("n3_t_busy", 32'(mc_busy_o), 32'd0);
    next();
    mc_start_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #2;
      check("n3_run_stall", 32'(stall_o), 32'b001111);
      check("n3_run_busy", 32'(mc_busy_o), 32'd1);
      check("n3_run_done", 32'(mc_done_o), 32'd0);
      next();
    end
    #2;
    check("n3_done", 32'(mc_done_o), 32'd1);
    check("n3_done_stall", 32'(stall_o), 32'd0);
    check("n3_done_busy", 32'(mc_busy_o), 32'd0);
    next();
    #2;
    check("n3_idle_done", 32'(mc_done_o), 32'd0);
    check("n3_idle_stall", 32'(stall_o), 32'd0);
    next();

    // Length boundaries: 0 and 1 both give 2 stall cycles, 63 gives 64.
    run_op(0, 2, "n0");
    run_op(1, 2, "n1");
    run_op(63, 64, "n63");

    // Flush at t+2 of an N=5 op aborts it with no done pulse.
    mc_cycles_i = 6'd5;
    mc_start_i  = 1'b1;
    next();
    mc_start_i = 1'b0;
    next();
    flush_i = 1'b1;
    #2;
    check("flush_flush_o", 32'(flush_o), 32'd1);
    check("flush_stall", 32'(stall_o), 32'd0);
    next();
    flush_i = 1'b0;
    #2;
    check("flush_idle_busy", 32'(mc_busy_o), 32'd0);
    check("flush_idle_stall", 32'(stall_o), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_done = saw_done | mc_done_o;
      next();
      #2;
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    next();

    // Flush together with a start in IDLE: op never enters RUN.
    flush_i    = 1'b1;
    mc_start_i = 1'b1;
    #2;
    check("flush_start_flush_o", 32'(flush_o), 32'd1);
    check("flush_start_stall", 32'(stall_o), 32'd0);
    next();
    clear_inputs();
    #2;
    check("flush_start_busy", 32'(mc_busy_o), 32'd0);
    check("flush_start_stall2", 32'(stall_o), 32'd0);
    next();

    // N=1: id stall during RUN keeps the ex vector; ex stall in DONE keeps the pulse.
    mc_cycles_i = 6'd1;
    mc_start_i  = 1'b1;
    next();
    mc_start_i    = 1'b0;
    stallreq_id_i = 1'b1;
    #2;
    check("id_in_run", 32'(stall_o), 32'b001111);
    next();
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b1;
    #2;
    check("ex_in_done_stall", 32'(stall_o), 32'b001111);
    check("ex_in_done_pulse", 32'(mc_done_o), 32'd1);
    next();
    clear_inputs();
    #2;
    check("after_done_idle", 32'(mc_busy_o), 32'd0);
    next();

    // Reset in the middle of RUN: back to IDLE with no done pulse.
    mc_cycles_i = 6'd10;
    mc_start_i  = 1'b1;
    next();
    mc_start_i = 1'b0;
    next();
    #2;
    check("pre_rst_busy", 32'(mc_busy_o), 32'd1);
    next();
    rst = 1'b1;
    #2;
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_busy", 32'(mc_busy_o), 32'd0);
    next();
    rst = 1'b0;
    #2;
    check("after_rst_busy", 32'(mc_busy_o), 32'd0);
    check("after_rst_done", 32'(mc_done_o), 32'd0);
    check("after_rst_stall", 32'(stall_o), 32'd0);
    next();

`ifdef PIPE_CTRL_STALL_STAT_EN
    // Clear the counters, then one N=3 op (4 cycles) plus one id stall = 5.
    rst = 1'b1;
    next();
    rst = 1'b0;
    #2;
    check("stat_cleared", stall_cycles_o, 32'd0);
    next();
    run_op(3, 4, "stat_n3");
    stallreq_id_i = 1'b1;
    next();
    stallreq_id_i = 1'b0;
    #2;
    check("stat_count", stall_cycles_o, 32'd5);
    check("stat_saturated", 32'(sat_cycles), 32'd3);
    next();
    flush_i = 1'b1;
    next();
    flush_i = 1'b0;
    #2;
    check("stat_flush_hold", stall_cycles_o, 32'd5);
    next();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
